// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel hobby-servo PWM generator with a shared frame counter.
// Each channel turns an angle code into a pulse width. Width and enable are latched only at the
// frame boundary, so a pulse never changes shape once it has started.
// Optional feature: define SERVO_PWM_SLEW_LIMIT_EN to limit how far the active width may move
// toward its target at each frame boundary (SLEW_STEP cycles per frame).
module servo_pwm_multi #(
  parameter int unsigned FREQ      = 50_000_000,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned ANGLE_W   = 8,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned SLEW_STEP = 50
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*ANGLE_W-1:0]  angle,
  input  logic [CHANNELS-1:0]          angle_valid,
  input  logic [CHANNELS-1:0]          enable,
  output logic [CHANNELS-1:0]          servo_pwm,
  output logic                         frame_start
);

  localparam int unsigned CYC_US     = FREQ / 1_000_000;
  localparam int unsigned MIN_CYC    = MIN_US * CYC_US;
  localparam int unsigned MAX_CYC    = MAX_US * CYC_US;
  localparam int unsigned PERIOD_CYC = PERIOD_US * CYC_US;
  localparam int unsigned CNT_W      = $clog2(PERIOD_CYC);
  localparam int unsigned CNT_W1     = CNT_W + 1;

  // 64-bit intermediates: shadow (<= 16 bits) times span (< 32 bits) cannot overflow.
  localparam longint unsigned SPAN    = 64'(MAX_CYC - MIN_CYC);
  localparam longint unsigned ANG_MAX = (64'd1 << ANGLE_W) - 64'd1;
  localparam longint unsigned MIN_L   = 64'(MIN_CYC);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_CYC);

  // Reject parameter sets where the pulse could not fit inside the frame.
  if (!((MIN_US < MAX_US) && (MAX_US < PERIOD_US))) begin : g_param_check
    $error("servo_pwm_multi: parameters must satisfy MIN_US < MAX_US < PERIOD_US");
  end

  typedef enum logic [1:0] {
    StOff,
    StHigh,
    StLow
  } state_e;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_init;
  logic              r_frame_start;
  logic              w_boundary;
  logic [CNT_W:0]    w_cnt_inc;

  // r_init makes the first edge after reset a frame boundary, so frame 0 starts right away.
  assign w_boundary = r_init | (r_cnt == LAST_CNT);
  assign w_cnt_inc  = {1'b0, r_cnt} + CNT_W1'(1);

  // Shared frame counter and frame_start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_init        <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_init        <= 1'b0;
      r_frame_start <= w_boundary;
      r_cnt         <= w_boundary ? '0 : w_cnt_inc[CNT_W-1:0];
    end
  end

  assign frame_start = r_frame_start;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ANGLE_W-1:0] r_shadow;
    logic [ANGLE_W-1:0] w_shadow_nxt;
    logic [CNT_W-1:0]   w_target;
    logic [CNT_W-1:0]   w_width_nxt;
    logic [CNT_W-1:0]   r_width;
    state_e             r_state;
    logic               r_pwm;

    // A write on the boundary edge itself already counts for the next frame.
    assign w_shadow_nxt = angle_valid[i] ? angle[i*ANGLE_W +: ANGLE_W] : r_shadow;
    assign w_target     = CNT_W'(MIN_L + (64'(w_shadow_nxt) * SPAN) / ANG_MAX);

`ifdef SERVO_PWM_SLEW_LIMIT_EN
    localparam int unsigned      STEP_CL = (SLEW_STEP > PERIOD_CYC - 1) ? PERIOD_CYC - 1
                                                                        : SLEW_STEP;
    localparam logic [CNT_W-1:0] STEP    = CNT_W'(STEP_CL);
    logic             w_up;
    logic [CNT_W-1:0] w_diff;

    // Step the active width toward the target by at most STEP cycles.
    always_comb begin
      w_up   = (w_target >= r_width);
      w_diff = w_up ? (w_target - r_width) : (r_width - w_target);
      if (w_diff > STEP) begin
        w_width_nxt = w_up ? (r_width + STEP) : (r_width - STEP);
      end else begin
        w_width_nxt = w_target;
      end
    end
`else
    assign w_width_nxt = w_target;
`endif

    // Shadow angle register, last write in a frame wins.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= '0;
      end else if (angle_valid[i]) begin
        r_shadow <= angle[i*ANGLE_W +: ANGLE_W];
      end
    end

    // Active width is loaded only at the frame boundary (also while the channel is off).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_width <= MIN_W;
      end else if (w_boundary) begin
        r_width <= w_width_nxt;
      end
    end

    // Per-channel pulse FSM with registered output; enable is sampled only at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= StOff;
        r_pwm   <= 1'b0;
      end else if (w_boundary) begin
        if (!enable[i]) begin
          r_state <= StOff;
          r_pwm   <= 1'b0;
        end else if (w_width_nxt != '0) begin
          r_state <= StHigh;
          r_pwm   <= 1'b1;
        end else begin
          r_state <= StLow;
          r_pwm   <= 1'b0;
        end
      end else if ((r_state == StHigh) && (w_cnt_inc == {1'b0, r_width})) begin
        // Next cycle's count equals the width: the pulse has lasted exactly r_width cycles.
        r_state <= StLow;
        r_pwm   <= 1'b0;
      end
    end

    assign servo_pwm[i] = r_pwm;
  end

endmodule
